// File: rtl/sdram_cmd_monitor.sv
// SDR SDRAM command-bus monitor: tracks PRE -> REF* -> LMR init, captures mode register, checks spacing/refresh.
// Latency: all outputs registered, updated one cycle after the sampled command.
// Backpressure: none, passive observer of the bus.
module sdram_cmd_monitor #(
    parameter int SDRAM_CHIPS   = 8,
    parameter int SDRAM_MIN_REF = 2
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   CLR,
    input  logic [SDRAM_CHIPS-1:0] CS_N,
    input  logic                   RAS_N,
    input  logic                   CAS_N,
    input  logic                   WE_N,
    input  logic                   CKE,
    input  logic                   DQM,
    input  logic [13:0]            SA,
    input  logic [1:0]             BA,
    input  logic [2:0]             RP,
    input  logic [3:0]             RFC,
    input  logic [2:0]             MRD,
    input  logic [15:0]            REF,
    output logic                   INIT_DONE,
    output logic [13:0]            MODE_REG,
    output logic [2:0]             CL_DET,
    output logic [1:0]             BL_DET,
    output logic [3:0]             REF_COUNT,
    output logic                   ERR_SEQ,
    output logic                   ERR_TIMING,
    output logic                   ERR_REFRESH
);

    typedef enum logic [2:0] {
        C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
        C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111
    } cmd_t;

    typedef enum logic [1:0] {S_PRE, S_REF, S_RUN} state_t;

    localparam logic [4:0] MIN_REF = 5'(SDRAM_MIN_REF);

    state_t      state, state_nxt;
    cmd_t        cmd, last_cmd;
    logic        is_cmd;
    logic [7:0]  gap;
    logic [15:0] ref_ctr;
    logic        seq_err, timing_err, refresh_err, ref_inc, capture;

    assign cmd    = (CKE && !(&CS_N)) ? cmd_t'({RAS_N, CAS_N, WE_N}) : C_NOP;
    assign is_cmd = (cmd != C_NOP);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)  state <= S_PRE;
        else if (CLR)  state <= S_PRE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        seq_err     = 1'b0;
        ref_inc     = 1'b0;
        capture     = 1'b0;
        timing_err  = 1'b0;
        refresh_err = 1'b0;
        unique case (state)
            S_PRE: begin
                if (cmd == C_PRE)  state_nxt = S_REF;
                else if (is_cmd)   seq_err   = 1'b1;
            end
            S_REF: begin
                unique case (cmd)
                    C_REF: ref_inc = 1'b1;
                    C_LMR: begin
                        if ({1'b0, REF_COUNT} >= MIN_REF) begin
                            state_nxt = S_RUN;
                            capture   = (BA == 2'd0);
                        end else begin
                            seq_err = 1'b1;
                        end
                    end
                    C_ACT, C_RD, C_WR, C_BST: seq_err = 1'b1;
                    default: ;
                endcase
            end
            S_RUN: capture = (cmd == C_LMR) && (BA == 2'd0);
            default: state_nxt = S_PRE;
        endcase
        if (state != S_RUN && !DQM)
            seq_err = 1'b1;
        // Spacing is measured from the previous command; a zero minimum can never trip since gap >= 0
        if (is_cmd) begin
            timing_err = ((last_cmd == C_PRE) && (gap < {5'd0, RP}))  ||
                         ((last_cmd == C_REF) && (gap < {4'd0, RFC})) ||
                         ((last_cmd == C_LMR) && (gap < {5'd0, MRD}));
        end
        refresh_err = (state == S_RUN) && (ref_ctr > REF);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            MODE_REG    <= '0;
            REF_COUNT   <= '0;
            ERR_SEQ     <= 1'b0;
            ERR_TIMING  <= 1'b0;
            ERR_REFRESH <= 1'b0;
            gap         <= '0;
            last_cmd    <= C_NOP;
            ref_ctr     <= '0;
        end else if (CLR) begin
            MODE_REG    <= '0;
            REF_COUNT   <= '0;
            ERR_SEQ     <= 1'b0;
            ERR_TIMING  <= 1'b0;
            ERR_REFRESH <= 1'b0;
            gap         <= '0;
            last_cmd    <= C_NOP;
            ref_ctr     <= '0;
        end else begin
            ERR_SEQ     <= ERR_SEQ     | seq_err;
            ERR_TIMING  <= ERR_TIMING  | timing_err;
            ERR_REFRESH <= ERR_REFRESH | refresh_err;
            if (ref_inc && REF_COUNT != 4'hF)
                REF_COUNT <= REF_COUNT + 4'd1;
            if (capture)
                MODE_REG <= SA;
            if (is_cmd) begin
                gap      <= 8'd1;
                last_cmd <= cmd;
            end else if (gap != 8'hFF) begin
                gap <= gap + 8'd1;
            end
            // Interval counter restarts on entry to running mode and on every refresh while running
            if (state != S_RUN)
                ref_ctr <= '0;
            else if (cmd == C_REF)
                ref_ctr <= '0;
            else if (ref_ctr != 16'hFFFF)
                ref_ctr <= ref_ctr + 16'd1;
        end
    end

    assign INIT_DONE = (state == S_RUN);
    assign CL_DET    = MODE_REG[6:4];
    assign BL_DET    = MODE_REG[1:0];

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Bench for sdram_cmd_monitor: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_sdram_cmd_monitor;

    localparam int MIN_REF = 2;
    localparam logic [2:0] NOP = 3'b111, PRE = 3'b010, RFR = 3'b001, LMR = 3'b000,
                           ACT = 3'b011;

    logic        CLK, RESET_N, CLR, RAS_N, CAS_N, WE_N, CKE, DQM;
    logic [7:0]  CS_N;
    logic [13:0] SA;
    logic [1:0]  BA;
    logic [2:0]  RP, MRD;
    logic [3:0]  RFC;
    logic [15:0] REF;
    logic        INIT_DONE, ERR_SEQ, ERR_TIMING, ERR_REFRESH;
    logic [13:0] MODE_REG;
    logic [2:0]  CL_DET;
    logic [1:0]  BL_DET;
    logic [3:0]  REF_COUNT;

    sdram_cmd_monitor #(.SDRAM_CHIPS(8), .SDRAM_MIN_REF(MIN_REF)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CLR(CLR), .CS_N(CS_N), .RAS_N(RAS_N),
        .CAS_N(CAS_N), .WE_N(WE_N), .CKE(CKE), .DQM(DQM), .SA(SA), .BA(BA),
        .RP(RP), .RFC(RFC), .MRD(MRD), .REF(REF), .INIT_DONE(INIT_DONE),
        .MODE_REG(MODE_REG), .CL_DET(CL_DET), .BL_DET(BL_DET), .REF_COUNT(REF_COUNT),
        .ERR_SEQ(ERR_SEQ), .ERR_TIMING(ERR_TIMING), .ERR_REFRESH(ERR_REFRESH)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase 0 = waiting for PRE, 1 = refreshing, 2 = running
    int          m_phase, m_refs, m_gap, m_last, m_since_ref;
    logic [13:0] m_mode;
    logic        m_eseq, m_etim, m_eref;

    function automatic void model_clear();
        m_phase = 0; m_refs = 0; m_gap = 0; m_last = 7; m_since_ref = 0;
        m_mode = '0; m_eseq = 0; m_etim = 0; m_eref = 0;
    endfunction

    function automatic void model_step();
        int c, nphase, nrefs;
        logic seq, tim, rfe;
        if (CLR) begin
            model_clear();
            return;
        end
        c = (CKE && CS_N != 8'hFF) ? int'({RAS_N, CAS_N, WE_N}) : 7;
        seq = 0; tim = 0; rfe = 0; nphase = m_phase; nrefs = m_refs;
        if (m_phase != 2 && !DQM) seq = 1;
        if (c != 7) begin
            if (m_last == 2 && m_gap < int'(RP))  tim = 1;
            if (m_last == 1 && m_gap < int'(RFC)) tim = 1;
            if (m_last == 0 && m_gap < int'(MRD)) tim = 1;
        end
        if (m_phase == 0) begin
            if (c == 2) nphase = 1;
            else if (c != 7) seq = 1;
        end else if (m_phase == 1) begin
            if (c == 1) nrefs = (m_refs < 15) ? m_refs + 1 : 15;
            if (c == 0) begin
                if (m_refs >= MIN_REF) begin
                    nphase = 2;
                    if (BA == 0) m_mode = SA;
                end else seq = 1;
            end
            if (c >= 3 && c <= 6) seq = 1;
        end else begin
            if (c == 0 && BA == 0) m_mode = SA;
            if (m_since_ref > int'(REF)) rfe = 1;
        end
        if (m_phase != 2) m_since_ref = 0;
        else if (c == 1) m_since_ref = 0;
        else if (m_since_ref < 65535) m_since_ref++;
        m_gap = (c != 7) ? 1 : ((m_gap < 255) ? m_gap + 1 : 255);
        if (c != 7) m_last = c;
        m_refs = nrefs; m_phase = nphase;
        m_eseq |= seq; m_etim |= tim; m_eref |= rfe;
    endfunction

    task automatic cyc(input logic [2:0] c3, input logic [13:0] sa, input logic [1:0] ba);
        {RAS_N, CAS_N, WE_N} = c3;
        SA = sa; BA = ba;
        model_step();
        @(posedge CLK);
        #1;
        n_vec++;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(NOP, 14'd0, 2'd0);
    endtask

    task automatic do_reset();
        CLR = 0; CS_N = 8'h00; CKE = 1; DQM = 1;
        {RAS_N, CAS_N, WE_N} = NOP; SA = '0; BA = '0;
        RESET_N = 0;
        model_clear();
        @(posedge CLK);
        #1;
        RESET_N = 1;
    endtask

    task automatic test_reset();
        RP = 3'd2; RFC = 4'd7; MRD = 3'd2; REF = 16'd1000;
        do_reset();
        if ({INIT_DONE, MODE_REG, CL_DET, BL_DET, REF_COUNT, ERR_SEQ, ERR_TIMING, ERR_REFRESH} !== '0)
            $display("FAIL reset_outputs: got %0h expected 0",
                     {INIT_DONE, MODE_REG, CL_DET, BL_DET, REF_COUNT, ERR_SEQ, ERR_TIMING, ERR_REFRESH});
        n_vec++;
        if ({INIT_DONE, MODE_REG, REF_COUNT, ERR_SEQ, ERR_TIMING, ERR_REFRESH} !== '0) n_err++;
    endtask

    task automatic test_proper_init();
        do_reset();
        cyc(PRE, 14'd0, 2'd0); nops(7);
        for (int i = 0; i < 8; i++) begin cyc(RFR, 14'd0, 2'd0); nops(7); end
        if (INIT_DONE !== 1'b0) begin n_err++; $display("FAIL init_before_lmr: got %b expected 0", INIT_DONE); end
        cyc(LMR, 14'h0033, 2'd0);
        if (INIT_DONE !== 1'b1) begin n_err++; $display("FAIL init_done: got %b expected 1", INIT_DONE); end
        if (MODE_REG !== 14'h0033) begin n_err++; $display("FAIL mode_reg: got %h expected 0033", MODE_REG); end
        if (CL_DET !== 3'd3 || BL_DET !== 2'd3) begin
            n_err++; $display("FAIL cl_bl: got %0d/%0d expected 3/3", CL_DET, BL_DET);
        end
        if (REF_COUNT !== 4'd8) begin n_err++; $display("FAIL ref_count: got %0d expected 8", REF_COUNT); end
        if ({ERR_SEQ, ERR_TIMING, ERR_REFRESH} !== 3'b000) begin
            n_err++; $display("FAIL init_errs: got %b expected 000", {ERR_SEQ, ERR_TIMING, ERR_REFRESH});
        end
        nops(3);
        cyc(LMR, 14'h1234, 2'd1);
        if (MODE_REG !== 14'h0033) begin n_err++; $display("FAIL ext_lmr: got %h expected 0033", MODE_REG); end
        nops(3);
        cyc(LMR, 14'h0021, 2'd0);
        if (MODE_REG !== 14'h0021 || CL_DET !== 3'd2 || BL_DET !== 2'd1) begin
            n_err++; $display("FAIL recapture: got %h expected 0021", MODE_REG);
        end
    endtask

    task automatic test_seq_order();
        do_reset();
        cyc(RFR, 14'd0, 2'd0);
        if (ERR_SEQ !== 1'b1) begin n_err++; $display("FAIL ref_first: got %b expected 1", ERR_SEQ); end
        if (REF_COUNT !== 4'd0) begin n_err++; $display("FAIL ref_first_count: got %0d expected 0", REF_COUNT); end
        nops(8);
        cyc(PRE, 14'd0, 2'd0); nops(3);
        cyc(RFR, 14'd0, 2'd0);
        if (REF_COUNT !== 4'd1) begin n_err++; $display("FAIL pre_advances: got %0d expected 1", REF_COUNT); end
    endtask

    task automatic test_timing_gap();
        do_reset();
        cyc(PRE, 14'd0, 2'd0);
        cyc(RFR, 14'd0, 2'd0);
        if (ERR_TIMING !== 1'b1) begin n_err++; $display("FAIL trp_short: got %b expected 1", ERR_TIMING); end
        do_reset();
        cyc(PRE, 14'd0, 2'd0); nops(1);
        cyc(RFR, 14'd0, 2'd0);
        if (ERR_TIMING !== 1'b0) begin n_err++; $display("FAIL trp_exact: got %b expected 0", ERR_TIMING); end
        nops(5);
        cyc(RFR, 14'd0, 2'd0);
        if (ERR_TIMING !== 1'b1) begin n_err++; $display("FAIL trfc_short: got %b expected 1", ERR_TIMING); end
        do_reset();
        RP = 3'd0; RFC = 4'd0;
        cyc(PRE, 14'd0, 2'd0); cyc(RFR, 14'd0, 2'd0); cyc(RFR, 14'd0, 2'd0);
        if (ERR_TIMING !== 1'b0) begin n_err++; $display("FAIL zero_min: got %b expected 0", ERR_TIMING); end
        RP = 3'd2; RFC = 4'd7;
    endtask

    task automatic test_min_ref_and_refresh();
        do_reset();
        REF = 16'd100;
        cyc(PRE, 14'd0, 2'd0); nops(7);
        cyc(RFR, 14'd0, 2'd0); nops(7);
        cyc(LMR, 14'h0033, 2'd0);
        if (ERR_SEQ !== 1'b1 || INIT_DONE !== 1'b0) begin
            n_err++; $display("FAIL too_few_refs: got seq=%b done=%b expected 1/0", ERR_SEQ, INIT_DONE);
        end
        nops(7); cyc(RFR, 14'd0, 2'd0); nops(7);
        cyc(LMR, 14'h0033, 2'd0);
        if (INIT_DONE !== 1'b1 || REF_COUNT !== 4'd2) begin
            n_err++; $display("FAIL second_lmr: got done=%b cnt=%0d expected 1/2", INIT_DONE, REF_COUNT);
        end
        nops(7); cyc(RFR, 14'd0, 2'd0);
        nops(101);
        if (ERR_REFRESH !== m_eref || ERR_REFRESH !== 1'b0) begin
            n_err++; $display("FAIL refresh_edge: got %b expected %b", ERR_REFRESH, m_eref);
        end
        nops(1);
        if (ERR_REFRESH !== 1'b1) begin n_err++; $display("FAIL refresh_late: got %b expected 1", ERR_REFRESH); end
        CLR = 1; cyc(NOP, 14'd0, 2'd0); CLR = 0;
        if ({INIT_DONE, MODE_REG, REF_COUNT, ERR_SEQ, ERR_TIMING, ERR_REFRESH} !== '0) begin
            n_err++; $display("FAIL clr: got %h expected 0", {INIT_DONE, MODE_REG, REF_COUNT, ERR_SEQ, ERR_TIMING, ERR_REFRESH});
        end
    endtask

    task automatic test_dqm_cke();
        do_reset();
        cyc(PRE, 14'd0, 2'd0); nops(3);
        DQM = 0; cyc(NOP, 14'd0, 2'd0); DQM = 1;
        if (ERR_SEQ !== 1'b1) begin n_err++; $display("FAIL dqm_in_ref: got %b expected 1", ERR_SEQ); end
        do_reset();
        CKE = 0; cyc(PRE, 14'd0, 2'd0); CKE = 1;
        CS_N = 8'hFF; cyc(PRE, 14'd0, 2'd0); CS_N = 8'h00;
        nops(2);
        cyc(RFR, 14'd0, 2'd0);
        if (ERR_SEQ !== 1'b1 || REF_COUNT !== 4'd0) begin
            n_err++; $display("FAIL cke_ignored: got seq=%b cnt=%0d expected 1/0", ERR_SEQ, REF_COUNT);
        end
        CLR = 1; cyc(ACT, 14'd0, 2'd0); CLR = 0;
        if (ERR_SEQ !== 1'b0) begin n_err++; $display("FAIL clr_priority: got %b expected 0", ERR_SEQ); end
    endtask

    task automatic rand_cycle(input bit mostly_nop);
        logic [2:0] c;
        c = (mostly_nop && $urandom_range(0, 9) < 6) ? NOP : 3'($urandom_range(0, 7));
        DQM  = ($urandom_range(0, 29) != 0);
        CKE  = ($urandom_range(0, 19) != 0);
        CS_N = ($urandom_range(0, 9) == 0) ? 8'hFF : ~(8'h01 << $urandom_range(0, 7));
        CLR  = ($urandom_range(0, 199) == 0);
        cyc(c, 14'($urandom), 2'($urandom_range(0, 1)));
        CLR = 0;
    endtask

    task automatic test_random();
        logic [27:0] got, exp;
        do_reset();
        for (int ep = 0; ep < 8; ep++) begin
            RP = 3'($urandom_range(0, 3)); RFC = 4'($urandom_range(0, 8));
            MRD = 3'($urandom_range(0, 3)); REF = 16'($urandom_range(20, 60));
            CS_N = 8'h00; CKE = 1; DQM = 1;
            CLR = 1; cyc(NOP, 14'd0, 2'd0); CLR = 0;
            cyc(PRE, 14'd0, 2'd0);
            for (int r = 0; r < int'($urandom_range(0, 4)); r++) begin
                nops($urandom_range(0, 9)); cyc(RFR, 14'd0, 2'd0);
            end
            nops($urandom_range(0, 3));
            cyc(LMR, 14'($urandom), 2'($urandom_range(0, 1)));
            for (int i = 0; i < 150; i++) begin
                rand_cycle(i < 100);
                got = {INIT_DONE, MODE_REG, CL_DET, BL_DET, REF_COUNT, ERR_SEQ, ERR_TIMING, ERR_REFRESH};
                exp = {m_phase == 2, m_mode, m_mode[6:4], m_mode[1:0], 4'(m_refs), m_eseq, m_etim, m_eref};
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL random ep%0d cyc%0d: got %h expected %h", ep, i, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_proper_init();
        test_seq_order();
        test_timing_gap();
        test_min_ref_and_refresh();
        test_dqm_cke();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
